// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: latency field width, the
// variable-latency code and the stall-cause encodings.
package hazard_pkg;

   localparam int unsigned LAT_W = 3;
   localparam logic [LAT_W-1:0] LONG = '1;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_LAT  = 2'b01;
   localparam logic [1:0] CAUSE_LONG = 2'b10;
   localparam logic [1:0] CAUSE_WAW  = 2'b11;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: busy/long flags plus a countdown to forwardability.
module hazard_sb_entry #(
   parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rec,
   input  logic [LAT_W-1:0] i_lat,
   input  logic             i_done,
   output logic             o_busy,
   output logic             o_long
);

   localparam logic [LAT_W-1:0] LatLong = {LAT_W{1'b1}};
   localparam logic [LAT_W-1:0] CntOne  = LAT_W'(1);

   logic             r_busy;
   logic             r_long;
   logic [LAT_W-1:0] r_cnt;
   logic             w_busy_nxt;
   logic             w_long_nxt;
   logic [LAT_W-1:0] w_cnt_nxt;

   // A new record always overrides both countdown and long completion.
   always_comb begin
      w_busy_nxt = r_busy;
      w_long_nxt = r_long;
      w_cnt_nxt  = r_cnt;
      if (i_rec) begin
         w_busy_nxt = (i_lat != '0);
         w_long_nxt = (i_lat == LatLong);
         w_cnt_nxt  = i_lat;
      end else if (r_busy && r_long) begin
         if (i_done) begin
            w_busy_nxt = 1'b0;
            w_long_nxt = 1'b0;
         end
      end else if (r_busy) begin
         w_cnt_nxt = r_cnt - CntOne;
         if (r_cnt == CntOne) begin
            w_busy_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_long <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_long <= w_long_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_busy = r_busy;
   assign o_long = r_long;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: tracks in-flight writers per register and raises a
// stall for RAW hazards and for writes over an outstanding long-latency result.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LAT_W    = hazard_pkg::LAT_W,
   parameter int unsigned STAT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   input  logic                issue_we,
   input  logic [REG_AW-1:0]   issue_rd,
   input  logic [LAT_W-1:0]    issue_lat,
   input  logic [REG_AW-1:0]   rs1_addr,
   input  logic [REG_AW-1:0]   rs2_addr,
   input  logic                rs1_used,
   input  logic                rs2_used,
   input  logic                long_done,
   input  logic [REG_AW-1:0]   long_rd,
   input  logic                flush,
   input  logic                stat_clear,
   output logic                stall,
   output logic [1:0]          stall_cause,
   output logic [NUM_REGS-1:0] pending,
   output logic [STAT_W-1:0]   stall_cnt
);

   import hazard_pkg::*;

   localparam logic [STAT_W-1:0] StatOne = STAT_W'(1);

   logic [NUM_REGS-1:0] w_busy;
   logic [NUM_REGS-1:0] w_long;
   logic                w_rec;
   logic                w_rs1_haz;
   logic                w_rs2_haz;
   logic                w_long_haz;
   logic                w_lat_haz;
   logic                w_waw;
   logic                w_stall;
   logic [1:0]          w_cause;
   logic [STAT_W-1:0]   r_stall_cnt;

   assign w_busy[0] = 1'b0;
   assign w_long[0] = 1'b0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      hazard_sb_entry #(
         .LAT_W (LAT_W)
      ) u_entry (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_rec  (w_rec && (issue_rd == REG_AW'(g))),
         .i_lat  (issue_lat),
         .i_done (long_done && (long_rd == REG_AW'(g))),
         .o_busy (w_busy[g]),
         .o_long (w_long[g])
      );
   end

   // A long result arriving this cycle is bypassed from writeback, so it does not stall.
   assign w_rs1_haz = rs1_used && (rs1_addr != '0) && w_busy[rs1_addr]
                      && !(w_long[rs1_addr] && long_done && (long_rd == rs1_addr));
   assign w_rs2_haz = rs2_used && (rs2_addr != '0) && w_busy[rs2_addr]
                      && !(w_long[rs2_addr] && long_done && (long_rd == rs2_addr));

   assign w_long_haz = (w_rs1_haz && w_long[rs1_addr]) || (w_rs2_haz && w_long[rs2_addr]);
   assign w_lat_haz  = (w_rs1_haz && !w_long[rs1_addr]) || (w_rs2_haz && !w_long[rs2_addr]);
   assign w_waw      = issue_valid && issue_we && w_long[issue_rd]
                       && !(long_done && (long_rd == issue_rd));

   assign w_stall = w_long_haz || w_lat_haz || w_waw;

   // Stall feeds back only into the record gate.
   assign w_rec = issue_valid && issue_we && !w_stall && !flush && (issue_rd != '0);

   always_comb begin
      w_cause = CAUSE_NONE;
      if (w_long_haz) begin
         w_cause = CAUSE_LONG;
      end else if (w_lat_haz) begin
         w_cause = CAUSE_LAT;
      end else if (w_waw) begin
         w_cause = CAUSE_WAW;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stat_clear) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + StatOne;
      end
   end

   assign stall       = w_stall;
   assign stall_cause = w_cause;
   assign pending     = w_busy;
   assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task drives one scenario and
// compares outputs against hand-derived values.
module tb_hazard_scoreboard;

   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned LW = 3;
   localparam int unsigned SW = 4;
   localparam logic [LW-1:0] LONG_C = 3'b111;

   logic          clk;
   logic          rst_n;
   logic          issue_valid;
   logic          issue_we;
   logic [AW-1:0] issue_rd;
   logic [LW-1:0] issue_lat;
   logic [AW-1:0] rs1_addr;
   logic [AW-1:0] rs2_addr;
   logic          rs1_used;
   logic          rs2_used;
   logic          long_done;
   logic [AW-1:0] long_rd;
   logic          flush;
   logic          stat_clear;
   logic          stall;
   logic [1:0]    stall_cause;
   logic [NR-1:0] pending;
   logic [SW-1:0] stall_cnt;

   int n_checks;
   int n_errs;

   hazard_scoreboard #(
      .NUM_REGS (NR),
      .REG_AW   (AW),
      .LAT_W    (LW),
      .STAT_W   (SW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_we    (issue_we),
      .issue_rd    (issue_rd),
      .issue_lat   (issue_lat),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_used    (rs1_used),
      .rs2_used    (rs2_used),
      .long_done   (long_done),
      .long_rd     (long_rd),
      .flush       (flush),
      .stat_clear  (stat_clear),
      .stall       (stall),
      .stall_cause (stall_cause),
      .pending     (pending),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic idle();
      issue_valid = 1'b0;
      issue_we    = 1'b0;
      issue_rd    = '0;
      issue_lat   = '0;
      rs1_addr    = '0;
      rs2_addr    = '0;
      rs1_used    = 1'b0;
      rs2_used    = 1'b0;
      long_done   = 1'b0;
      long_rd     = '0;
      flush       = 1'b0;
      stat_clear  = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
      issue_valid = 1'b1;
      issue_we    = 1'b1;
      issue_rd    = rd;
      issue_lat   = lat;
   endtask

   task automatic test_reset();
      idle();
      rst_n    = 1'b0;
      rs1_used = 1'b1;
      rs1_addr = 5'd5;
      #1;
      n_checks++;
      if (pending !== '0) begin
         n_errs++; $display("FAIL reset_pending: got %h want 0", pending);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL reset_stall: got %b want 0", stall);
      end
      n_checks++;
      if (stall_cause !== 2'b00) begin
         n_errs++; $display("FAIL reset_cause: got %b want 00", stall_cause);
      end
      n_checks++;
      if (stall_cnt !== 4'd0) begin
         n_errs++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      @(negedge clk); idle(); issue(5'd5, 3'd1); #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL lu_issue_stall: got %b want 0", stall);
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd5; #1;
      n_checks++;
      if (stall !== 1'b1 || stall_cause !== 2'b01) begin
         n_errs++; $display("FAIL lu_stall: got %b/%b want 1/01", stall, stall_cause);
      end
      n_checks++;
      if (pending[5] !== 1'b1) begin
         n_errs++; $display("FAIL lu_pending_busy: got %b want 1", pending[5]);
      end
      @(negedge clk); #1;
      n_checks++;
      if (stall !== 1'b0 || pending[5] !== 1'b0) begin
         n_errs++; $display("FAIL lu_release: got %b/%b want 0/0", stall, pending[5]);
      end
      n_checks++;
      if (stall_cnt !== 4'd1) begin
         n_errs++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
      end
   endtask

   task automatic test_alu();
      @(negedge clk); idle(); issue(5'd7, 3'd0); #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL alu_issue_stall: got %b want 0", stall);
      end
      @(negedge clk); idle();
      rs1_used = 1'b1; rs1_addr = 5'd7; rs2_used = 1'b1; rs2_addr = 5'd7; #1;
      n_checks++;
      if (stall !== 1'b0 || pending[7] !== 1'b0) begin
         n_errs++; $display("FAIL alu_read: got %b/%b want 0/0", stall, pending[7]);
      end
   endtask

   task automatic test_long();
      @(negedge clk); idle(); issue(5'd9, LONG_C); #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL long_issue_stall: got %b want 0", stall);
      end
      // A stalled ID instruction writing x12 must never be recorded.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); idle(); rs2_used = 1'b1; rs2_addr = 5'd9; issue(5'd12, 3'd3); #1;
         n_checks++;
         if (stall !== 1'b1 || stall_cause !== 2'b10) begin
            n_errs++;
            $display("FAIL long_stall_%0d: got %b/%b want 1/10", i, stall, stall_cause);
         end
      end
      @(negedge clk); idle(); rs2_used = 1'b1; rs2_addr = 5'd9; long_done = 1'b1;
      long_rd = 5'd9; #1;
      n_checks++;
      if (stall !== 1'b0 || pending[9] !== 1'b1) begin
         n_errs++; $display("FAIL long_bypass: got %b/%b want 0/1", stall, pending[9]);
      end
      @(negedge clk); idle(); rs2_used = 1'b1; rs2_addr = 5'd9; #1;
      n_checks++;
      if (stall !== 1'b0 || pending[9] !== 1'b0) begin
         n_errs++; $display("FAIL long_clear: got %b/%b want 0/0", stall, pending[9]);
      end
      n_checks++;
      if (pending[12] !== 1'b0) begin
         n_errs++; $display("FAIL long_no_record: got %b want 0", pending[12]);
      end
   endtask

   task automatic test_waw();
      @(negedge clk); idle(); issue(5'd3, LONG_C); #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL waw_issue_stall: got %b want 0", stall);
      end
      @(negedge clk); idle(); issue(5'd3, 3'd2); #1;
      n_checks++;
      if (stall !== 1'b1 || stall_cause !== 2'b11) begin
         n_errs++; $display("FAIL waw_stall: got %b/%b want 1/11", stall, stall_cause);
      end
      @(negedge clk); idle(); issue(5'd3, 3'd2); rs1_used = 1'b1; rs1_addr = 5'd3; #1;
      n_checks++;
      if (stall !== 1'b1 || stall_cause !== 2'b10) begin
         n_errs++; $display("FAIL waw_prio_long: got %b/%b want 1/10", stall, stall_cause);
      end
      @(negedge clk); idle(); issue(5'd3, 3'd2); #1;
      n_checks++;
      if (stall !== 1'b1 || stall_cause !== 2'b11) begin
         n_errs++; $display("FAIL waw_stall2: got %b/%b want 1/11", stall, stall_cause);
      end
      // Record and completion on x3 in the same cycle: the record must win.
      @(negedge clk); idle(); issue(5'd3, 3'd2); long_done = 1'b1; long_rd = 5'd3; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL waw_done_stall: got %b want 0", stall);
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd3; #1;
      n_checks++;
      if (pending[3] !== 1'b1 || stall_cause !== 2'b01) begin
         n_errs++; $display("FAIL waw_record_wins: got %b/%b want 1/01", pending[3], stall_cause);
      end
      @(negedge clk); idle(); #1;
      @(negedge clk); idle(); #1;
      n_checks++;
      if (pending[3] !== 1'b0) begin
         n_errs++; $display("FAIL waw_drain: got %b want 0", pending[3]);
      end
   endtask

   task automatic test_priority();
      @(negedge clk); idle(); issue(5'd10, LONG_C); #1;
      @(negedge clk); idle(); issue(5'd11, 3'd2); #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL prio_issue_stall: got %b want 0", stall);
      end
      @(negedge clk); idle();
      rs1_used = 1'b1; rs1_addr = 5'd11; rs2_used = 1'b1; rs2_addr = 5'd10; #1;
      n_checks++;
      if (stall !== 1'b1 || stall_cause !== 2'b10) begin
         n_errs++; $display("FAIL prio_long_over_lat: got %b/%b want 1/10", stall, stall_cause);
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd11; #1;
      n_checks++;
      if (stall !== 1'b1 || stall_cause !== 2'b01) begin
         n_errs++; $display("FAIL prio_lat2: got %b/%b want 1/01", stall, stall_cause);
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd11; #1;
      n_checks++;
      if (stall !== 1'b0 || stall_cause !== 2'b00) begin
         n_errs++; $display("FAIL prio_lat_done: got %b/%b want 0/00", stall, stall_cause);
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd10; long_done = 1'b1;
      long_rd = 5'd10; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_errs++; $display("FAIL prio_rs1_bypass: got %b want 0", stall);
      end
      @(negedge clk); idle(); #1;
      n_checks++;
      if (pending[10] !== 1'b0) begin
         n_errs++; $display("FAIL prio_x10_clear: got %b want 0", pending[10]);
      end
   endtask

   task automatic test_x0_flush();
      @(negedge clk); idle(); issue(5'd0, 3'd1); #1;
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd0; #1;
      n_checks++;
      if (pending !== '0 || stall !== 1'b0) begin
         n_errs++; $display("FAIL x0_write: got %h/%b want 0/0", pending, stall);
      end
      @(negedge clk); idle(); issue(5'd4, 3'd2); flush = 1'b1; #1;
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd4; #1;
      n_checks++;
      if (stall !== 1'b0 || pending[4] !== 1'b0) begin
         n_errs++; $display("FAIL flush_no_record: got %b/%b want 0/0", stall, pending[4]);
      end
   endtask

   task automatic test_counter();
      @(negedge clk); idle(); stat_clear = 1'b1; #1;
      @(negedge clk); idle(); issue(5'd9, LONG_C); #1;
      n_checks++;
      if (stall_cnt !== 4'd0) begin
         n_errs++; $display("FAIL cnt_cleared: got %0d want 0", stall_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd9;
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd9; stat_clear = 1'b1; #1;
      n_checks++;
      if (stall_cnt !== 4'd15) begin
         n_errs++; $display("FAIL cnt_saturate: got %0d want 15", stall_cnt);
      end
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd9; #1;
      n_checks++;
      if (stall_cnt !== 4'd0 || stall !== 1'b1) begin
         n_errs++; $display("FAIL cnt_clear_wins: got %0d/%b want 0/1", stall_cnt, stall);
      end
      @(negedge clk); #1;
      n_checks++;
      if (stall_cnt !== 4'd1) begin
         n_errs++; $display("FAIL cnt_restart: got %0d want 1", stall_cnt);
      end
      rst_n = 1'b0; #1;
      n_checks++;
      if (pending !== '0 || stall !== 1'b0 || stall_cause !== 2'b00 || stall_cnt !== 4'd0) begin
         n_errs++;
         $display("FAIL cnt_async_reset: got %h/%b/%b/%0d want 0/0/00/0",
                  pending, stall, stall_cause, stall_cnt);
      end
      @(negedge clk); idle(); rst_n = 1'b1; long_done = 1'b1; long_rd = 5'd9; #1;
      @(negedge clk); idle(); rs1_used = 1'b1; rs1_addr = 5'd9; #1;
      n_checks++;
      if (stall !== 1'b0 || pending[9] !== 1'b0) begin
         n_errs++; $display("FAIL reset_forgets_long: got %b/%b want 0/0", stall, pending[9]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      test_reset();
      test_load_use();
      test_alu();
      test_long();
      test_waw();
      test_priority();
      test_x0_flush();
      test_counter();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Param NUM_REGS, default 32: architectural register count; x0 is hardwired zero.
REQ-002 Param REG_AW, default 5: register address width, equal to clog2(NUM_REGS).
REQ-003 Param LAT_W, default 3: latency field width; the all-ones code LONG means variable latency.
REQ-004 Param STAT_W, default 16: stall counter width.
REQ-005 Ports (name  direction  width  meaning), with clock and reset first, SHALL be as follows; the design uses one clock, and reset is asynchronous and active-low:
  clk  in  1  rising-edge clock.
  rst_n  in  1  asynchronous active-low reset.
  issue_valid  in  1  the ID instruction advances to EX this cycle unless stall or flush is high.
  issue_we  in  1  the ID instruction writes rd.
  issue_rd  in  REG_AW  destination register.
  issue_lat  in  LAT_W  cycles until the result can be forwarded (0 = ALU, 1 = load, LONG = variable).
  rs1_addr, rs2_addr  in  REG_AW  ID source registers.
  rs1_used, rs2_used  in  1  the source is actually read.
  long_done  in  1  the variable-latency unit delivers a result this cycle.
  long_rd  in  REG_AW  destination of that result.
  flush  in  1  kill the ID instruction.
  stat_clear  in  1  synchronous clear of stall_cnt.
  stall  out  1  hold PC and IF/ID; bubble into EX.
  stall_cause  out  2  00 none, 01 latency (load-use), 10 long busy, 11 WAW on long.
  pending  out  NUM_REGS  per-register busy vector.
  stall_cnt  out  STAT_W  saturating count of stalled cycles.

Function
REQ-006 Each register r ≠ 0 SHALL hold an entry {busy, long, cnt[LAT_W]}; entry 0 SHALL never be busy.
REQ-007 "Record" SHALL mean issue_valid & issue_we & !stall & !flush & issue_rd ≠ 0; at the next edge, entry[issue_rd] loads busy = (issue_lat ≠ 0), long = (issue_lat == LONG), cnt = issue_lat.
REQ-008 A busy, non-long entry SHALL decrement cnt every cycle; when cnt = 1 it SHALL clear busy at the next edge.
REQ-009 A long entry SHALL stay busy until long_done with long_rd equal to it; busy and long then clear at the next edge.
REQ-010 Source hazard: if rsN_used, rsN_addr ≠ 0, and entry[rsN_addr].busy, stall SHALL be high combinationally, except when the entry is long and long_done & long_rd == rsN_addr in the same cycle (writeback bypass).
REQ-011 WAW hazard: if issue_valid & issue_we and entry[issue_rd] is long and not completing this cycle, stall SHALL be high.
REQ-012 stall_cause priority SHALL be 10 over 01 over 11 when multiple conditions hold; it SHALL be 00 when stall is low.
REQ-013 A non-long busy entry overwritten by a record SHALL take the new values, so the youngest writer wins.
REQ-014 If a record and a long completion hit the same register in one cycle, the record SHALL win.
REQ-015 long_done for a register that is not long-busy SHALL be ignored.
REQ-016 flush SHALL suppress recording only; existing entries keep counting.
REQ-017 stall SHALL not depend on flush, and stall with flush both high SHALL record nothing.
REQ-018 stall_cnt SHALL increment on every cycle with stall high, saturate at all-ones, and clear on stat_clear; stat_clear wins over an increment.
REQ-019 pending[r] SHALL equal entry[r].busy, registered with no combinational path.
REQ-020 There SHALL be no combinational path from stall to any input-side logic other than the record gate.

Reset
REQ-021 While rst_n is low, all entries SHALL clear and stall_cnt SHALL be 0; pending SHALL be 0 immediately, without waiting for a clock edge.
REQ-022 With all entries clear, stall and stall_cause SHALL be 0 whenever rst_n is low.
REQ-023 After reset deasserts mid-operation, in-flight long results SHALL be forgotten, and a later long_done for them SHALL be ignored.

Structure
REQ-024 Package hazard_pkg SHALL hold LAT_W, the LONG code, and the stall_cause encoding constants.
REQ-025 One sub-module, hazard_sb_entry, SHALL implement a single register entry (busy/long/cnt plus its next-state logic) and SHALL be instantiated NUM_REGS-1 times.
REQ-026 The top level SHALL hold the source/WAW compare muxes, the cause priority logic, and the stat counter.

Verification
REQ-027 Load-use: issue x5 with lat=1, then ID reads rs1=x5 on the next cycle -> stall=1 and cause=01 for exactly 1 cycle, then stall=0 and pending[5]=0.
REQ-028 ALU back-to-back: issue x7 with lat=0, then ID reads x7 -> stall never asserts and pending[7] stays 0.
REQ-029 Long op: issue x9 with LONG, ID reads rs2=x9 for 6 cycles, then long_done with long_rd=9 -> stall=1 with cause=10 for 6 cycles, stall=0 in the long_done cycle, and pending[9]=0 the cycle after.
REQ-030 WAW: x3 long pending, then issue a write to x3 with lat=0 -> stall with cause=11 until long_done on x3.
REQ-031 x0 and flush: issue x0 with lat=1 -> pending stays 0; issue x4 with lat=2 plus flush -> nothing recorded; a following read of x4 -> no stall.
REQ-032 Counter: with STAT_W=4, hold a long stall for 20 cycles -> stall_cnt=15; then stat_clear -> 0; assert rst_n low mid-stall -> pending=0 immediately.
